mem_dbus_ctrl: RTL and testbench
================================

// Module: mem_dbus_ctrl
// PURPOSE
// - MEM stage of the 5-stage MIPS32 pipeline, directly downstream of the EX/MEM pipeline register.
// - Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus, big-endian.
// - Holds the pipeline through ctrl until the access completes.
// - Passes non-memory results through unchanged to the MEM/WB register.
// PARAMETERS
// - BUS_TIMEOUT  255  cycles in BUSY without dbus_ack_i before the access is aborted; 0 = never time out
// PORTS
// - clk            in   1   pipeline clock; single clock domain
// - rst            in   1   synchronous, active-high reset (`RstEnable)
// - wd_i           in   5   destination register from EX/MEM
// - wreg_i         in   1   register write enable from EX/MEM
// - wdata_i        in   32  ALU result from EX/MEM
// - aluop_i        in   8   `AluOpBus` opcode; load/store codes come from defines.v
// - mem_addr_i     in   32  effective byte address
// - reg2_i         in   32  store data; not needed for loads
// - stall          in   6   ctrl stall vector; stall[4] = MEM stage stopped
// - wd_o           out  5   destination register to MEM/WB
// - wreg_o         out  1   write enable to MEM/WB
// - wdata_o        out  32  result to MEM/WB
// - stallreq_o     out  1   stall request to ctrl
// - dbus_req_o     out  1   bus request; held until ack or abort
// - dbus_we_o      out  1   1 = store
// - dbus_addr_o    out  32  word-aligned address ({mem_addr_i[31:2],2'b00})
// - dbus_sel_o     out  4   byte enables; bit3 = byte 0 (big-endian)
// - dbus_wdata_o   out  32  store data replicated/aligned into the selected lanes
// - dbus_ack_i     in   1   one-cycle completion strobe
// - dbus_rdata_i   in   32  read data; valid only when dbus_ack_i=1
// - err_o          out  1   one-cycle pulse on misalignment or timeout
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; wd_o=`NOPRegAddr`; timeout counter=0. Reset mid-access drops dbus_req_o on the next edge.
// - Non-memory op: wd_o/wreg_o/wdata_o = inputs combinationally. stallreq_o=0. No bus activity.
// - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0): no bus cycle; wreg_o=0; err_o=1 for exactly one cycle.
// - Byte-lane rules:
//   - addr[1:0]=00 selects byte lane [31:24].
//   - SB: sel=1000>>addr[1:0], wdata={4{reg2[7:0]}}.
//   - SH: sel=1100 or 0011, wdata={2{reg2[15:0]}}.
//   - SW: sel=1111.
//   - LB/LH: sign-extend the selected lane. LBU/LHU: zero-extend.
// - FSM:
//   - IDLE: aligned load/store present -> register req/we/addr/sel/wdata -> BUSY.
//     - stallreq_o=1 combinationally in the same cycle.
//   - BUSY: stallreq_o=1; counter increments.
//     - dbus_ack_i -> capture aligned load data into rbuf; drop req -> DONE.
//     - Timeout (BUSY_TIMEOUT reached) -> drop req; err_o pulse; wreg_o=0 -> DONE.
//   - DONE: stallreq_o=0; wdata_o=rbuf for loads; wreg_o=0 for stores.
//     - stall[4]=`NoStop` -> IDLE.
//     - Otherwise hold DONE and never reissue.
// - Minimum load/store latency: 2 stall cycles (issue, ack) plus the DONE cycle.
// - dbus_ack_i outside BUSY is ignored.
// - aluop_i changes while in BUSY are ignored; the access latched at issue completes.
// - New request issued the cycle after DONE->IDLE if the next op is memory; no idle gap is inserted.
// STRUCTURE
// - defines.v holds load/store `EXE_*_OP` codes and FSM state encodings (`DbusIdle/`DbusBusy/`DbusDone).
// - New constant `DbusSelBus` is added to defines.v.
// - One combinational sub-module, mem_lane_align, performs:
//   - sel generation
//   - store-data replication
//   - load extract/extend
// - FSM, timeout counter and rbuf live in mem_dbus_ctrl.
// TESTING
// - LW addr 0x100, ack after 3 cycles, rdata 0x11223344:
//   - req held 3 cycles; stallreq_o=1 throughout.
//   - DONE gives wdata_o=0x11223344, wreg_o=1.
// - LB addr 0x103 with rdata 0x000000F0 -> wdata_o=0xFFFFFFF0. LBU, same stimulus -> 0x000000F0.
// - SH addr 0x102, reg2 0xAAAA5678 -> sel=0011, wdata=0x56785678, we=1; wreg_o=0 after ack.
// - LW addr 0x101 -> no req; err_o one-cycle pulse; wreg_o=0; stallreq_o=0.
// - BUS_TIMEOUT=4, no ack:
//   - req drops after 4 BUSY cycles; err_o pulses once.
//   - FSM returns to IDLE when stall[4]=0.
// - rst=1 in the second BUSY cycle:
//   - req=0 and stallreq_o=0 next edge.
//   - A late ack is ignored; no register write.

Source files
------------

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared opcodes, FSM state type and opcode classifiers for the MEM-stage data bus controller.
package mem_dbus_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
    localparam int         DBUS_SEL_W   = 4;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'd0,
        DBUS_BUSY = 2'd1,
        DBUS_DONE = 2'd2
    } dbus_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

endpackage

// File: rtl/mem_dbus_ctrl_lane_align.sv
// Big-endian byte-lane logic: byte enables, store-data replication and load extract/extend.
module mem_lane_align
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [7:0]            aluop,
    input  logic [1:0]            addr_lo,
    input  logic [31:0]           reg2,
    input  logic [31:0]           rdata,
    output logic [DBUS_SEL_W-1:0] sel,
    output logic [31:0]           wdata,
    output logic [31:0]           load_data,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        is_load    = is_load_op(aluop);
        is_store   = is_store_op(aluop);
        sel        = '0;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;

        case (aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel = 4'b1000 >> addr_lo;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                misaligned = addr_lo[0];
            end
            EXE_LW_OP, EXE_SW_OP: begin
                sel        = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase

        case (aluop)
            EXE_LB_OP:  load_data = {{24{byte_lane[7]}}, byte_lane};
            EXE_LBU_OP: load_data = {24'b0, byte_lane};
            EXE_LH_OP:  load_data = {{16{half_lane[15]}}, half_lane};
            EXE_LHU_OP: load_data = {16'b0, half_lane};
            EXE_LW_OP:  load_data = rdata;
            EXE_SB_OP:  wdata     = {4{reg2[7:0]}};
            EXE_SH_OP:  wdata     = {2{reg2[15:0]}};
            EXE_SW_OP:  wdata     = reg2;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM stage: runs loads/stores over a req/ack data bus and stalls the pipeline until they finish.
//  state | meaning
//  IDLE  | pass-through; an aligned load/store issues the bus request
//  BUSY  | request outstanding; waits for ack or timeout
//  DONE  | result presented to MEM/WB; waits for the stage to advance
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [7:0]            aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           reg2_i,
    input  logic [5:0]            stall,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stallreq_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [31:0]           dbus_addr_o,
    output logic [DBUS_SEL_W-1:0] dbus_sel_o,
    output logic [31:0]           dbus_wdata_o,
    input  logic                  dbus_ack_i,
    input  logic [31:0]           dbus_rdata_i,
    output logic                  err_o
);

    localparam bit          TMO_EN   = (BUS_TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

    dbus_state_e state;
    logic [7:0]  aluop_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic        tmo_q;
    logic        err_q;
    logic [15:0] tmo_cnt;

    logic [7:0]            op_cur;
    logic [1:0]            addr_cur;
    logic [DBUS_SEL_W-1:0] lane_sel;
    logic [31:0]           lane_wdata;
    logic [31:0]           load_data;
    logic                  is_load;
    logic                  is_store;
    logic                  misaligned;
    logic                  timeout_hit;
    logic                  unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    // Once an access is issued the lane logic works from the latched op, not the live inputs.
    assign op_cur      = (state == DBUS_IDLE) ? aluop_i : aluop_q;
    assign addr_cur    = (state == DBUS_IDLE) ? mem_addr_i[1:0] : addr_lo_q;
    assign timeout_hit = TMO_EN && (tmo_cnt == TMO_LAST);

    mem_lane_align u_lane (
        .aluop      (op_cur),
        .addr_lo    (addr_cur),
        .reg2       (reg2_i),
        .rdata      (dbus_rdata_i),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned)
    );

    always_comb begin
        wd_o       = NOP_REG_ADDR;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        err_o      = 1'b0;
        if (!rst) begin
            unique case (state)
                DBUS_IDLE: begin
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    if (is_load || is_store) begin
                        stallreq_o = !misaligned;
                        err_o      = misaligned;
                    end else begin
                        wreg_o = wreg_i;
                    end
                end
                DBUS_BUSY: begin
                    stallreq_o = 1'b1;
                    wd_o       = wd_q;
                end
                DBUS_DONE: begin
                    wd_o    = wd_q;
                    wreg_o  = wreg_q && is_load && !tmo_q;
                    wdata_o = is_load ? rbuf : wdata_q;
                    err_o   = err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DBUS_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_sel_o   <= '0;
            dbus_wdata_o <= '0;
            aluop_q      <= '0;
            addr_lo_q    <= '0;
            wd_q         <= NOP_REG_ADDR;
            wreg_q       <= 1'b0;
            wdata_q      <= '0;
            rbuf         <= '0;
            tmo_q        <= 1'b0;
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                DBUS_IDLE: begin
                    if ((is_load || is_store) && !misaligned) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel_o   <= lane_sel;
                        dbus_wdata_o <= lane_wdata;
                        aluop_q      <= aluop_i;
                        addr_lo_q    <= mem_addr_i[1:0];
                        wd_q         <= wd_i;
                        wreg_q       <= wreg_i;
                        wdata_q      <= wdata_i;
                        tmo_q        <= 1'b0;
                        tmo_cnt      <= '0;
                        state        <= DBUS_BUSY;
                    end
                end
                DBUS_BUSY: begin
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        dbus_we_o  <= 1'b0;
                        if (is_load) begin
                            rbuf <= load_data;
                        end
                        state <= DBUS_DONE;
                    end else if (timeout_hit) begin
                        dbus_req_o <= 1'b0;
                        dbus_we_o  <= 1'b0;
                        tmo_q      <= 1'b1;
                        err_q      <= 1'b1;
                        state      <= DBUS_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DBUS_DONE: begin
                    if (!stall[4]) begin
                        state <= DBUS_IDLE;
                    end
                end
                default: state <= DBUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl with a write-back scoreboard and a simple ctrl stall model.
module tb_mem_dbus_ctrl;
    import mem_dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [5:0]  stall;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        err_o;
    logic        hold_mem;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    always #5 clk = ~clk;

    assign stall = (stallreq_o || hold_mem) ? 6'b011111 : 6'b000000;

    mem_dbus_ctrl #(.BUS_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .reg2_i       (reg2_i),
        .stall        (stall),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .stallreq_o   (stallreq_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_sel_o   (dbus_sel_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_ack_i   (dbus_ack_i),
        .dbus_rdata_i (dbus_rdata_i),
        .err_o        (err_o)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_data;
        logic        err;
    } wb_t;

    wb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic tb_is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic tb_is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic tb_misaligned(input logic [7:0] op, input logic [1:0] a);
        if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return a[0];
        if (op inside {EXE_LW_OP, EXE_SW_OP}) return a != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] tb_sel(input logic [7:0] op, input logic [1:0] a);
        if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 4'b1000 >> a;
        if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return a[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] tb_store_data(input logic [7:0] op, input logic [31:0] r2);
        if (op == EXE_SB_OP) return {r2[7:0], r2[7:0], r2[7:0], r2[7:0]};
        if (op == EXE_SH_OP) return {r2[15:0], r2[15:0]};
        return r2;
    endfunction

    function automatic logic [31:0] tb_load(input logic [7:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * (3 - int'(a))));
        h = 16'(rd >> (a[1] ? 0 : 16));
        case (op)
            EXE_LB_OP:  return {{24{b[7]}}, b};
            EXE_LBU_OP: return {24'h0, b};
            EXE_LH_OP:  return {{16{h[15]}}, h};
            EXE_LHU_OP: return {16'h0, h};
            default:    return rd;
        endcase
    endfunction

    // Presents one op to the stage and follows it until the stage releases the pipeline.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] alu, input logic [4:0] wd,
                          input logic wr, input int ack_at, input logic [31:0] rdata,
                          input bit chg_op);
        wb_t         e;
        wb_t         got_e;
        logic        mem;
        logic        mis;
        int          req_c = 0;
        int          stall_c = 0;
        int          err_c = 0;
        int          exp_req;
        bit          seen = 0;
        bit          done = 0;
        logic [31:0] addr_seen = '0;
        logic [31:0] wdat_seen = '0;
        logic [3:0]  sel_seen = '0;
        logic        we_seen = 1'b0;

        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = reg2;
        wdata_i    = alu;
        wd_i       = wd;
        wreg_i     = wr;

        mem = tb_is_load(op) || tb_is_store(op);
        mis = mem && tb_misaligned(op, addr[1:0]);
        e.wd = wd;
        e.wdata = alu;
        if (!mem) begin
            e.wreg = wr; e.chk_data = 1'b1; e.err = 1'b0;
        end else if (mis || ack_at == 0) begin
            e.wreg = 1'b0; e.chk_data = 1'b0; e.err = 1'b1;
        end else if (tb_is_load(op)) begin
            e.wreg = wr; e.chk_data = 1'b1; e.err = 1'b0;
            e.wdata = tb_load(op, addr[1:0], rdata);
        end else begin
            e.wreg = 1'b0; e.chk_data = 1'b0; e.err = 1'b0;
        end
        sb_q.push_back(e);

        for (int cyc = 0; cyc < 40; cyc++) begin
            dbus_ack_i   = (ack_at > 0) && (cyc == ack_at);
            dbus_rdata_i = dbus_ack_i ? rdata : 32'hDEAD_BEEF;
            if (chg_op && cyc == 1) begin
                aluop_i    = OP_NOP;
                mem_addr_i = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            if (dbus_req_o) begin
                req_c++;
                if (!seen) begin
                    seen      = 1;
                    addr_seen = dbus_addr_o;
                    sel_seen  = dbus_sel_o;
                    we_seen   = dbus_we_o;
                    wdat_seen = dbus_wdata_o;
                end
            end
            if (stallreq_o) stall_c++;
            if (err_o) err_c++;
            if (!stallreq_o) begin
                done  = 1;
                got_e = sb_q.pop_front();
                check({tag, "_wd"}, 32'(wd_o), 32'(got_e.wd));
                check({tag, "_wreg"}, 32'(wreg_o), 32'(got_e.wreg));
                if (got_e.chk_data) check({tag, "_wdata"}, wdata_o, got_e.wdata);
                check({tag, "_err_pulses"}, 32'(err_c), 32'(got_e.err));
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_released"}, 32'(done), 32'd1);

        exp_req = (!mem || mis) ? 0 : ((ack_at == 0) ? 4 : ack_at);
        check({tag, "_req_cycles"}, 32'(req_c), 32'(exp_req));
        check({tag, "_stall_cycles"}, 32'(stall_c), (exp_req == 0) ? 32'd0 : 32'(exp_req + 1));
        if (exp_req > 0) begin
            check({tag, "_addr"}, addr_seen, {addr[31:2], 2'b00});
            check({tag, "_sel"}, 32'(sel_seen), 32'(tb_sel(op, addr[1:0])));
            check({tag, "_we"}, 32'(we_seen), 32'(tb_is_store(op)));
            if (tb_is_store(op)) check({tag, "_bus_wdata"}, wdat_seen, tb_store_data(op, reg2));
        end

        @(posedge clk);
        #1;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;
    endtask

    initial begin
        rst          = 1'b1;
        hold_mem     = 1'b0;
        aluop_i      = OP_ADD;
        mem_addr_i   = 32'h0000_0100;
        reg2_i       = 32'h0;
        wdata_i      = 32'h1234_5678;
        wd_i         = 5'd3;
        wreg_i       = 1'b1;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wd", 32'(wd_o), 32'(NOP_REG_ADDR));
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_req", 32'(dbus_req_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("add",    OP_ADD,     32'h0,        32'h0,        32'hA5A5_0001, 5'd3, 1'b1, 0, 32'h0,        1'b0);
        run_op("lw",     EXE_LW_OP,  32'h0000_0100, 32'h0,       32'h0000_0100, 5'd4, 1'b1, 3, 32'h1122_3344, 1'b0);
        run_op("lb",     EXE_LB_OP,  32'h0000_0103, 32'h0,       32'h0000_0103, 5'd5, 1'b1, 1, 32'h0000_00F0, 1'b0);
        run_op("lbu",    EXE_LBU_OP, 32'h0000_0103, 32'h0,       32'h0000_0103, 5'd6, 1'b1, 1, 32'h0000_00F0, 1'b0);
        run_op("sh",     EXE_SH_OP,  32'h0000_0102, 32'hAAAA_5678, 32'h0000_0102, 5'd7, 1'b1, 2, 32'h0,      1'b0);
        run_op("lh",     EXE_LH_OP,  32'h0000_0102, 32'h0,       32'h0000_0102, 5'd8, 1'b1, 1, 32'h1234_8001, 1'b0);
        run_op("lhu",    EXE_LHU_OP, 32'h0000_0100, 32'h0,       32'h0000_0100, 5'd9, 1'b1, 2, 32'h8001_1234, 1'b0);
        run_op("sb",     EXE_SB_OP,  32'h0000_0101, 32'h0000_12AB, 32'h0000_0101, 5'd0, 1'b0, 1, 32'h0,      1'b0);
        run_op("sw",     EXE_SW_OP,  32'h0000_0104, 32'hCAFE_BABE, 32'h0000_0104, 5'd0, 1'b0, 1, 32'h0,      1'b0);
        run_op("lb_chg", EXE_LB_OP,  32'h0000_0201, 32'h0,       32'h0000_0201, 5'd10, 1'b1, 1, 32'h7F80_0000, 1'b1);
        run_op("lw_mis", EXE_LW_OP,  32'h0000_0101, 32'h0,       32'h0000_0101, 5'd11, 1'b1, 1, 32'h0,        1'b0);
        run_op("lh_mis", EXE_LH_OP,  32'h0000_0103, 32'h0,       32'h0000_0103, 5'd12, 1'b1, 1, 32'h0,        1'b0);
        run_op("lw_tmo", EXE_LW_OP,  32'h0000_0300, 32'h0,       32'h0000_0300, 5'd13, 1'b1, 0, 32'h0,        1'b0);
        run_op("add2",   OP_ADD,     32'h0,        32'h0,        32'h0BAD_F00D, 5'd14, 1'b1, 0, 32'h0,        1'b0);

        // Downstream stall keeps the stage in DONE; it must not re-issue.
        hold_mem = 1'b1;
        run_op("lw_hold", EXE_LW_OP, 32'h0000_0104, 32'h0,       32'h0000_0104, 5'd15, 1'b1, 1, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_req", 32'(dbus_req_o), 32'd0);
            check("hold_stallreq", 32'(stallreq_o), 32'd0);
            check("hold_wdata", wdata_o, 32'hCAFE_F00D);
            @(posedge clk);
            #1;
        end
        hold_mem = 1'b0;
        @(posedge clk);
        #1;
        run_op("after_hold", OP_ADD, 32'h0, 32'h0, 32'h0000_0042, 5'd16, 1'b1, 0, 32'h0, 1'b0);

        // Reset during the second BUSY cycle, followed by a stray ack.
        aluop_i    = EXE_LW_OP;
        mem_addr_i = 32'h0000_0200;
        wd_i       = 5'd17;
        wreg_i     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req_still", 32'(dbus_req_o), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_req", 32'(dbus_req_o), 32'd0);
        check("mid_rst_stallreq", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        aluop_i      = OP_NOP;
        wreg_i       = 1'b0;
        wdata_i      = 32'h0000_0055;
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'h9999_9999;
        @(negedge clk);
        check("late_ack_wreg", 32'(wreg_o), 32'd0);
        check("late_ack_wdata", wdata_o, 32'h0000_0055);
        check("late_ack_stallreq", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        dbus_ack_i = 1'b0;
        @(negedge clk);
        check("late_ack_req", 32'(dbus_req_o), 32'd0);
        check("late_ack_err", 32'(err_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
